// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receive path.
// Frame FSM states and the data-bit count used by the receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int         PS2_DATA_BITS  = 8;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer and glitch filter for the PS/2 clock line.
// Emits a registered one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fall_evt
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             filt_p2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      filt_p2  <= 1'b1;
      cnt      <= '0;
      fall_evt <= 1'b0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      fall_evt <= 1'b0;
      // Level only flips once the disagreeing sample has persisted FILTER_LEN cycles
      if (sync_p1 == filt_p2) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt_p2  <= sync_p1;
        cnt      <= '0;
        fall_evt <= filt_p2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// Delivers validated scan codes with a one-cycle strobe; aborts stalled frames.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic       busy
);

  localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int                BIT_W   = $clog2(PS2_DATA_BITS);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX = BIT_W'(PS2_DATA_BITS - 1);

  logic                     fall_evt;
  logic                     data_p0;
  logic                     data_p1;
  ps2_state_t               state;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]         bit_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     parity_ok;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .raw     (ps2_clk),
    .fall_evt(fall_evt)
  );

  // Data needs no filtering: it is only looked at on a filtered clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      tmo_cnt          <= '0;
      parity_ok        <= 1'b0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      frame_error      <= 1'b0;

      if (fall_evt || state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fall_evt && !data_p1) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (fall_evt) begin
            shift_reg <= {data_p1, shift_reg[PS2_DATA_BITS-1:1]};
            if (bit_cnt == BIT_MAX) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (fall_evt) begin
            parity_ok <= (^shift_reg) ^ data_p1;
            state     <= STOP;
          end
        end
        STOP: begin
          if (fall_evt) begin
            if (data_p1 && parity_ok) begin
              received_data    <= shift_reg;
              received_data_en <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A clock edge in the same cycle keeps the frame alive
      if (state != IDLE && !fall_evt && tmo_cnt == TMO_MAX) begin
        state       <= IDLE;
        frame_error <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: valid frames, parity error, glitch,
// timeout and mid-frame reset, with a clock scaled so one PS/2 bit is 80 clk cycles.
`timescale 1ns/1ps
module tb_ps2_scan_receiver;

  localparam int FILTER_LEN = 4;
  localparam int TMO        = 200;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int cyc = 0, fall_cnt = 0, en_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_fall_cyc = 0, last_en_cyc = 0;
  logic [7:0] last_en_data = 8'h00;
  int glitch_falls = 0;

  ps2_scan_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .frame_error     (frame_error),
    .busy            (busy)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dut.u_clk_filter.fall_evt) begin
      fall_cnt      <= fall_cnt + 1;
      last_fall_cyc <= cyc;
    end
    if (received_data_en) begin
      en_cnt       <= en_cnt + 1;
      last_en_cyc  <= cyc;
      last_en_data <= received_data;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
    if (received_data_en && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    int f0;
    ps2_data = b;
    if (glitch) begin
      tick(5);
      f0 = fall_cnt;
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(8);
      glitch_falls = fall_cnt - f0;
      tick(HALF / 2 - 15);
    end else begin
      tick(HALF / 2);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input int glitch_bit);
    logic [10:0] fr;
    fr = {1'b1, p, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(fr[i], i == glitch_bit);
  endtask

  task automatic test_reset;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(3);
    vectors++; if (received_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", received_data); end
    vectors++; if (received_data_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", received_data_en); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", frame_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(10);
  endtask

  task automatic test_single_frame;
    int e0, x0;
    e0 = en_cnt; x0 = err_cnt;
    send_frame(8'h1C, 1'b0, -1);
    vectors++; if (en_cnt - e0 !== 1) begin miscompares++; $display("FAIL single_en_count: got %0d want 1", en_cnt - e0); end
    vectors++; if (last_en_data !== 8'h1C) begin miscompares++; $display("FAIL single_strobe_data: got %h want 1c", last_en_data); end
    vectors++; if (received_data !== 8'h1C) begin miscompares++; $display("FAIL single_data_hold: got %h want 1c", received_data); end
    vectors++; if (err_cnt - x0 !== 0) begin miscompares++; $display("FAIL single_err: got %0d want 0", err_cnt - x0); end
    vectors++; if (last_en_cyc - last_fall_cyc !== 1) begin miscompares++; $display("FAIL single_latency: got %0d want 1", last_en_cyc - last_fall_cyc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int e0, x0;
    e0 = en_cnt; x0 = err_cnt;
    send_frame(8'hF0, 1'b1, -1);
    vectors++; if (received_data !== 8'hF0) begin miscompares++; $display("FAIL b2b_first: got %h want f0", received_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_gap: got %b want 0", busy); end
    send_frame(8'h15, 1'b0, -1);
    vectors++; if (received_data !== 8'h15) begin miscompares++; $display("FAIL b2b_second: got %h want 15", received_data); end
    vectors++; if (en_cnt - e0 !== 2) begin miscompares++; $display("FAIL b2b_en_count: got %0d want 2", en_cnt - e0); end
    vectors++; if (err_cnt - x0 !== 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", err_cnt - x0); end
  endtask

  task automatic test_parity_error;
    int e0, x0;
    e0 = en_cnt; x0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1);
    vectors++; if (err_cnt - x0 !== 1) begin miscompares++; $display("FAIL parity_err_count: got %0d want 1", err_cnt - x0); end
    vectors++; if (en_cnt - e0 !== 0) begin miscompares++; $display("FAIL parity_no_en: got %0d want 0", en_cnt - e0); end
    vectors++; if (received_data !== 8'h15) begin miscompares++; $display("FAIL parity_data_kept: got %h want 15", received_data); end
    send_frame(8'h29, 1'b0, -1);
    vectors++; if (received_data !== 8'h29) begin miscompares++; $display("FAIL parity_recover: got %h want 29", received_data); end
    vectors++; if (en_cnt - e0 !== 1) begin miscompares++; $display("FAIL parity_recover_en: got %0d want 1", en_cnt - e0); end
  endtask

  task automatic test_glitch;
    int f0, x0;
    f0 = fall_cnt; x0 = err_cnt;
    glitch_falls = -1;
    send_frame(8'h5A, 1'b1, 4);
    vectors++; if (glitch_falls !== 0) begin miscompares++; $display("FAIL glitch_fall: got %0d want 0", glitch_falls); end
    vectors++; if (fall_cnt - f0 !== 11) begin miscompares++; $display("FAIL glitch_frame_falls: got %0d want 11", fall_cnt - f0); end
    vectors++; if (received_data !== 8'h5A) begin miscompares++; $display("FAIL glitch_data: got %h want 5a", received_data); end
    vectors++; if (err_cnt - x0 !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d want 0", err_cnt - x0); end
  endtask

  task automatic test_timeout;
    int e0, x0, waited;
    e0 = en_cnt; x0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL timeout_busy_mid: got %b want 1", busy); end
    waited = 0;
    while (err_cnt == x0 && waited < 2 * TMO) begin
      tick(1);
      waited++;
    end
    vectors++; if (err_cnt - x0 !== 1) begin miscompares++; $display("FAIL timeout_err: got %0d want 1 after %0d cycles", err_cnt - x0, waited); end
    vectors++; if (waited < TMO - 2 * HALF || waited > TMO) begin miscompares++; $display("FAIL timeout_delay: got %0d want %0d..%0d", waited, TMO - 2 * HALF, TMO); end
    tick(2);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy_after: got %b want 0", busy); end
    vectors++; if (en_cnt - e0 !== 0) begin miscompares++; $display("FAIL timeout_no_en: got %0d want 0", en_cnt - e0); end
    send_frame(8'h66, 1'b1, -1);
    vectors++; if (received_data !== 8'h66) begin miscompares++; $display("FAIL timeout_recover: got %h want 66", received_data); end
    vectors++; if (err_cnt - x0 !== 1) begin miscompares++; $display("FAIL timeout_recover_err: got %0d want 1", err_cnt - x0); end
  endtask

  task automatic test_reset_mid_frame;
    int e0, x0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    e0 = en_cnt; x0 = err_cnt;
    reset = 1'b1;
    tick(1);
    vectors++; if (received_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h want 00", received_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (received_data_en !== 1'b0 || frame_error !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobes: got en=%b err=%b want 0 0", received_data_en, frame_error); end
    reset = 1'b0;
    tick(5);
    send_frame(8'h1D, 1'b1, -1);
    vectors++; if (received_data !== 8'h1D) begin miscompares++; $display("FAIL rstmid_recover: got %h want 1d", received_data); end
    vectors++; if (en_cnt - e0 !== 1) begin miscompares++; $display("FAIL rstmid_en_count: got %0d want 1", en_cnt - e0); end
    vectors++; if (err_cnt - x0 !== 0) begin miscompares++; $display("FAIL rstmid_err: got %0d want 0", err_cnt - x0); end
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL strobes_exclusive: got %0d overlaps want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Upstream stage of the keyboard key decoder. Receives raw PS/2 device-to-host frames on the `ps2_clk` and `ps2_data` pins.
- Delivers each validated 8-bit scan code (make codes, 0xF0 break prefix, 0xE0 extended prefix) as `received_data`, qualified by a one-cycle `received_data_en` strobe.
- Filters line glitches, checks odd parity and the stop bit, and aborts stalled frames on timeout.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz) before the frame is aborted.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous reset, active-high.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- received_data  output  8  last valid scan code; holds its value between frames.
- received_data_en  output  1  one-cycle strobe marking a new valid `received_data`.
- frame_error  output  1  one-cycle strobe on parity, stop-bit or timeout failure.
- busy  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high. At reset: `received_data`=0x00, `received_data_en`=0, `frame_error`=0, `busy`=0, FSM=IDLE, shift register, bit counter and timeout counter cleared, filtered clock=1.
- Input conditioning: both pins pass through a 2-FF synchronizer.
  - The filtered clock changes level only after FILTER_LEN consecutive equal synchronized samples.
  - `fall_evt` is a registered one-cycle pulse on each 1->0 transition of the filtered clock.
  - Data is sampled from the synchronized ps2_data in the cycle `fall_evt` is high.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall_evt` with data=0 (start bit), go to DATA and clear the bit counter. On `fall_evt` with data=1, stay in IDLE and flag nothing.
  - DATA: on each `fall_evt`, shift the sample in LSB-first (new bit enters at bit 7 and shifts right). After the 8th bit, go to PARITY.
  - PARITY: on `fall_evt`, latch `parity_ok` = (XOR of the 8 data bits XOR sampled parity bit) == 1 (odd parity). Go to STOP.
  - STOP: on `fall_evt`, if sample==1 and `parity_ok`, load `received_data` from the shift register and pulse `received_data_en`; otherwise pulse `frame_error`. Return to IDLE in both cases.
- Latency: `received_data` and `received_data_en` update in the same cycle, exactly one clk after the `fall_evt` cycle of the stop bit.
- Strobes: `received_data_en` and `frame_error` are each high for exactly one cycle per frame and are never high together.
- `received_data` changes only on a valid frame. A failed frame leaves the previous value intact.
- Timeout: the counter clears on every `fall_evt` and in IDLE, and increments otherwise.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses `frame_error`.
  - If the timeout and a `fall_evt` land in the same cycle, `fall_evt` wins and the frame continues.
- Reset mid-frame: abort immediately to reset values. No strobe is produced for the partial frame.
- Transmit (host-to-device) is not supported. The block never drives the pins.
- Counter widths are sized with $clog2 of the parameters. No wrap is possible, because the timeout counter saturates at its abort point.

Decomposition:
- Package `ps2_pkg`:
  - State enum `ps2_state_t` {IDLE, DATA, PARITY, STOP}.
  - Constants PS2_DATA_BITS=8 and PS2_BREAK_CODE=8'hF0.
- Sub-module `ps2_line_filter`: 2-FF synchronizer plus FILTER_LEN glitch filter, with `fall_evt` output. Instantiated once for ps2_clk. ps2_data uses only the synchronizer.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> `received_data`=0x1C, `received_data_en` high for 1 cycle, one clk after the stop-bit `fall_evt`; `frame_error`=0.
- Back-to-back 0xF0 (parity 1) then 0x15 (parity 0) -> two strobes, values 0xF0 then 0x15, `busy` low between frames.
- 0x1C sent with parity bit 1 -> `frame_error` pulse, no `received_data_en`, `received_data` keeps its prior value; a following 0x29 frame is received correctly.
- 2-cycle low glitch on ps2_clk with FILTER_LEN=4 mid-frame -> no `fall_evt`, and a frame of 0x5A still decodes to 0x5A.
- Start bit plus 3 data bits, then the clock held high -> after TIMEOUT_CYCLES `frame_error` pulses and `busy`=0; the next 0x66 frame decodes correctly.
- `reset` asserted after the 5th data bit -> all outputs 0 on the next clk; a fresh 0x1D frame decodes correctly with no stray strobe.
